// File: rtl/pri_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc_pkg
// Description : Shared constants and helpers for the pending-request priority
//               encoder (index width and one-hot decode).
// Revision    : 1.0 - initial release
// ============================================================================
package pri_enc_pkg;

    localparam int MAX_N = 64;

    // Ceiling log2, evaluated at elaboration for index widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One-hot decode of idx, limited to the low n bits.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_N; i++) begin
            result[i] = (i == idx) && (i < n);
        end
        return result;
    endfunction

endpackage : pri_enc_pkg
`default_nettype wire

// File: rtl/pri_enc_find.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc_find
// Description : Combinational search of a request vector, starting at index
//               'start' and moving downward with wrap from 0 to N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_enc_find
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] w_pos;

    // First hit in search order wins; later hits are masked by 'found'.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = W'((int'(start) + N - k) % N);
            if (!found && vec[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule : pri_enc_find
`default_nettype wire

// File: rtl/pri_enc_pending.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc_pending
// Description : Sticky pending-request register with a valid/ready index
//               output; each request bit is reported once and then cleared.
//               Define PRI_ENC_RR_EN for rotating priority (fixed otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module pri_enc_pending
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         busy
);

    localparam logic [W-1:0] c_top_idx = W'(N - 1);

    logic [N-1:0] r_pending;
    logic         r_out_valid;
    logic [W-1:0] r_out_idx;

    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic         w_slot;
    logic         w_grant;
    logic         w_found;
    logic [W-1:0] w_g_idx;
    logic [W-1:0] w_start;

`ifdef PRI_ENC_RR_EN
    logic [W-1:0] r_rr_ptr;

    // Search begins just below the last granted index, wrapping past 0.
    assign w_start = (r_rr_ptr == '0) ? c_top_idx : r_rr_ptr - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= c_top_idx;
        end else if (w_grant) begin
            r_rr_ptr <= w_g_idx;
        end
    end
`else
    assign w_start = c_top_idx;
`endif

    pri_enc_find #(
        .N (N),
        .W (W)
    ) u_find (
        .vec   (r_pending),
        .start (w_start),
        .idx   (w_g_idx),
        .found (w_found)
    );

    assign w_set   = en ? req_in : '0;
    assign w_slot  = !r_out_valid || out_ready;
    // found is exactly |r_pending, so this is slot & |pending.
    assign w_grant = w_slot && w_found;
    assign w_clr   = w_grant ? N'(onehot(int'(w_g_idx), N)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_slot) begin
                r_out_valid <= w_grant;
                if (w_grant) begin
                    r_out_idx <= w_g_idx;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign pending   = r_pending;
    assign busy      = (|r_pending) || r_out_valid;

endmodule : pri_enc_pending
`default_nettype wire

// File: tb/tb_pri_enc_pending.sv
`default_nettype none
// ============================================================================
// Module      : tb_pri_enc_pending
// Description : Self-checking directed-vector bench for pri_enc_pending (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pri_enc_pending;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       busy;

    int n_checks;
    int n_pass;

    pri_enc_pending #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_in    (req_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       b;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                                input logic y, input logic v, input logic [2:0] i,
                                input logic [7:0] p, input logic b);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.rdy = y;
        t.v = v; t.idx = i; t.pend = p; t.b = b;
        return t;
    endfunction

    task automatic check(input string name, input int step, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic step_apply(input logic r, input logic e, input logic [7:0] q,
                              input logic y);
        rst = r; en = e; req_in = q; out_ready = y;
        @(posedge clk);
        #1;
    endtask

`ifndef PRI_ENC_RR_EN
    localparam int NROWS = 31;
    vec_t tbl [NROWS];
`endif
    logic [2:0] drain_seq [8];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; en = 1'b1; req_in = 8'hFF; out_ready = 1'b1;

`ifndef PRI_ENC_RR_EN
        //           rst  en   req    rdy   v    idx   pend   busy
        tbl[0]  = mk(1'b1,1'b1,8'hFF,1'b1, 1'b0,3'd0, 8'h00,1'b0);
        tbl[1]  = mk(1'b1,1'b1,8'hFF,1'b1, 1'b0,3'd0, 8'h00,1'b0);
        tbl[2]  = mk(1'b0,1'b1,8'h01,1'b1, 1'b0,3'd0, 8'h01,1'b1);
        tbl[3]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd0, 8'h00,1'b1);
        tbl[4]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b0,3'd0, 8'h00,1'b0);
        tbl[5]  = mk(1'b0,1'b1,8'hA4,1'b1, 1'b0,3'd0, 8'hA4,1'b1);
        tbl[6]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd7, 8'h24,1'b1);
        tbl[7]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd5, 8'h04,1'b1);
        tbl[8]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd2, 8'h00,1'b1);
        tbl[9]  = mk(1'b0,1'b1,8'h00,1'b1, 1'b0,3'd2, 8'h00,1'b0);
        tbl[10] = mk(1'b0,1'b1,8'hA4,1'b1, 1'b0,3'd2, 8'hA4,1'b1);
        tbl[11] = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd7, 8'h24,1'b1);
        tbl[12] = mk(1'b0,1'b1,8'h00,1'b0, 1'b1,3'd7, 8'h24,1'b1);
        tbl[13] = mk(1'b0,1'b1,8'h00,1'b0, 1'b1,3'd7, 8'h24,1'b1);
        tbl[14] = mk(1'b0,1'b1,8'h00,1'b0, 1'b1,3'd7, 8'h24,1'b1);
        tbl[15] = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd5, 8'h04,1'b1);
        tbl[16] = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd2, 8'h00,1'b1);
        tbl[17] = mk(1'b0,1'b1,8'h00,1'b1, 1'b0,3'd2, 8'h00,1'b0);
        tbl[18] = mk(1'b0,1'b1,8'h08,1'b0, 1'b0,3'd2, 8'h08,1'b1);
        tbl[19] = mk(1'b0,1'b1,8'h10,1'b0, 1'b1,3'd3, 8'h10,1'b1);
        tbl[20] = mk(1'b0,1'b0,8'hFF,1'b0, 1'b1,3'd3, 8'h10,1'b1);
        tbl[21] = mk(1'b0,1'b0,8'hFF,1'b1, 1'b1,3'd4, 8'h00,1'b1);
        tbl[22] = mk(1'b0,1'b0,8'hFF,1'b1, 1'b0,3'd4, 8'h00,1'b0);
        tbl[23] = mk(1'b0,1'b1,8'h02,1'b1, 1'b0,3'd4, 8'h02,1'b1);
        tbl[24] = mk(1'b0,1'b1,8'h02,1'b1, 1'b1,3'd1, 8'h02,1'b1);
        tbl[25] = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd1, 8'h00,1'b1);
        tbl[26] = mk(1'b0,1'b1,8'h00,1'b1, 1'b0,3'd1, 8'h00,1'b0);
        tbl[27] = mk(1'b0,1'b1,8'hFF,1'b1, 1'b0,3'd1, 8'hFF,1'b1);
        tbl[28] = mk(1'b0,1'b1,8'h00,1'b1, 1'b1,3'd7, 8'h7F,1'b1);
        tbl[29] = mk(1'b1,1'b1,8'h00,1'b1, 1'b0,3'd0, 8'h00,1'b0);
        tbl[30] = mk(1'b0,1'b1,8'h00,1'b1, 1'b0,3'd0, 8'h00,1'b0);

        for (int i = 0; i < NROWS; i++) begin
            step_apply(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].rdy);
            check("out_valid", i, {7'd0, out_valid}, {7'd0, tbl[i].v});
            check("out_idx",   i, {5'd0, out_idx},   {5'd0, tbl[i].idx});
            check("pending",   i, pending,           tbl[i].pend);
            check("busy",      i, {7'd0, busy},      {7'd0, tbl[i].b});
        end

        for (int i = 0; i < 8; i++) drain_seq[i] = 3'(7 - i);
`else
        for (int i = 0; i < 7; i++) drain_seq[i] = 3'(6 - i);
        drain_seq[7] = 3'd7;
`endif

        // All lines requested once: expect N back-to-back grants, then idle.
        step_apply(1'b1, 1'b1, 8'h00, 1'b1);
        check("rst_valid", 100, {7'd0, out_valid}, 8'h00);
        check("rst_pend",  100, pending, 8'h00);
        step_apply(1'b0, 1'b1, 8'hFF, 1'b1);
        check("all_pend",  101, pending, 8'hFF);
        check("all_valid", 101, {7'd0, out_valid}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step_apply(1'b0, 1'b1, 8'h00, 1'b1);
            check("drain_valid", 102 + i, {7'd0, out_valid}, 8'h01);
            check("drain_idx",   102 + i, {5'd0, out_idx}, {5'd0, drain_seq[i]});
        end
        step_apply(1'b0, 1'b1, 8'h00, 1'b1);
        check("drain_end_valid", 110, {7'd0, out_valid}, 8'h00);
        check("drain_end_busy",  110, {7'd0, busy}, 8'h00);
        check("drain_end_idx",   110, {5'd0, out_idx}, {5'd0, drain_seq[7]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pri_enc_pending
`default_nettype wire
